// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: image geometry, FSM states
// and the RGB565 -> RGB444 packing rule.
package cam_pkg;

    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int IMG_SIZE   = IMG_W * IMG_H;
    // First address past the image; the reader uses it as its black pixel.
    localparam int BLACK_ADDR = IMG_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FS,
        CAPTURE,
        FRAME_END
    } cam_state_e;

    function automatic logic [11:0] rgb565_to_rgb444(input logic [7:0] hi,
                                                     input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into pixels: holds the hi byte, and on the lo byte
// presents the packed RGB444 pixel combinationally.
module cam_byte_pack
    import cam_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        pix_valid,
    output logic [11:0] pix_data
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    // Any gap in byte_en (href low, frame end, not capturing) realigns to a hi byte.
    always_comb begin
        phase_d = byte_en ? ~phase_q : 1'b0;
        hi_d    = (byte_en && !phase_q) ? byte_in : hi_q;
    end

    assign pix_valid = byte_en & phase_q;
    assign pix_data  = rgb565_to_rgb444(hi_q, byte_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-to-frame-buffer writer: frame sync FSM, pixel address counter and
// registered write port towards the dual-port buffer.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = cam_pkg::IMG_W,
    parameter int IMG_H = cam_pkg::IMG_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          overflow
);

    localparam logic [AW-1:0] SIZE_A = AW'(IMG_W * IMG_H);

    cam_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          vsync_q;

    logic          fs, fe, byte_en, pix_valid;
    logic [11:0]   pix_data;

    assign fs = vsync_q & ~vsync;
    assign fe = ~vsync_q & vsync;
    // Frame end beats a byte arriving in the same cycle; the pending hi byte is dropped.
    assign byte_en = (state_q == CAPTURE) && href && !fe;

    cam_byte_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .byte_en   (byte_en),
        .byte_in   (px_data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_FS;
            end
            WAIT_FS: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (fs) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (fe) begin
                    state_d = FRAME_END;
                    done_d  = 1'b1;
                end else if (pix_valid) begin
                    // Counter saturates at the image size so the black pixel is never written.
                    if (cnt_q < SIZE_A) begin
                        addr_d = cnt_q;
                        data_d = pix_data;
                        wr_d   = 1'b1;
                        cnt_d  = cnt_q + AW'(1);
                    end else begin
                        ovf_d  = 1'b1;
                    end
                end
            end
            FRAME_END: begin
                state_d = capture_en ? WAIT_FS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            vsync_q <= vsync;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign frame_done  = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed frame sequence with random pixel bytes, checked against a
// line/pixel-level reference model of the expected buffer writes.
module tb_cam_frame_writer;

    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int SIZE = W * H;

    logic          clk = 1'b0;
    logic          rst, capture_en, vsync, href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr, frame_done, overflow;

    always #5 clk = ~clk;

    cam_frame_writer #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .vsync       (vsync),
        .href        (href),
        .px_data     (px_data),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int got_addr[$], got_data[$];
    int exp_addr[$], exp_data[$];
    int done_cnt = 0;

    int   mcnt;
    bit   movf;
    bit   model_on;
    int   pix_k;
    logic [7:0] lb[$];

    always @(negedge clk) begin
        if (px_wr === 1'b1) begin
            got_addr.push_back(int'(mem_px_addr));
            got_data.push_back(int'(mem_px_data));
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    function automatic int ref_pack(input int hi, input int lo);
        int r, g, b;
        r = hi / 16;
        g = (hi % 8) * 2 + lo / 128;
        b = (lo / 2) % 16;
        return r * 256 + g * 16 + b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        href  = 1'b0;
        tick(4);
        vsync = 1'b0;
        if (model_on) begin
            mcnt = 0;
            movf = 1'b0;
        end
        pix_k = 0;
        tick(2);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        href  = 1'b0;
        tick(3);
    endtask

    task automatic fill_k(input int npx);
        for (int j = 0; j < npx; j++) begin
            lb.push_back(pix_k[15:8]);
            lb.push_back(pix_k[7:0]);
            pix_k++;
        end
    endtask

    task automatic fill_rand(input int nbytes);
        for (int j = 0; j < nbytes; j++) lb.push_back(8'($urandom));
    endtask

    // Drives one href line, then updates the model: whole byte pairs become
    // pixels in order, an odd trailing byte is lost, pixels past SIZE overflow.
    task automatic send_line();
        for (int i = 0; i < lb.size(); i++) begin
            href    = 1'b1;
            px_data = lb[i];
            tick(1);
        end
        href    = 1'b0;
        px_data = 8'd0;
        tick(2);
        if (model_on) begin
            for (int i = 0; i + 1 < lb.size(); i += 2) begin
                if (mcnt < SIZE) begin
                    exp_addr.push_back(mcnt);
                    exp_data.push_back(ref_pack(int'(lb[i]), int'(lb[i+1])));
                    mcnt++;
                end else begin
                    movf = 1'b1;
                end
            end
        end
        lb.delete();
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, " write count"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " addr"}, got_addr[i], exp_addr[i]);
            chk({tag, " data"}, got_data[i], exp_data[i]);
        end
        $display("%s: %0d writes checked", tag, n);
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        rst = 1'b1; capture_en = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'd0;
        model_on = 1'b0; mcnt = 0; movf = 1'b0; pix_k = 0;
        tick(3);
        chk("reset px_wr", px_wr, 0);
        chk("reset addr", mem_px_addr, 0);
        chk("reset data", mem_px_data, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overflow", overflow, 0);
        rst = 1'b0;
        tick(1);

        // Frame A: known colours, odd-length line, then a normal line.
        capture_en = 1'b1; model_on = 1'b1; done_cnt = 0;
        frame_start();
        lb.push_back(8'hF8); lb.push_back(8'h1F); lb.push_back(8'h07); lb.push_back(8'hE0);
        send_line();
        fill_rand(7);  send_line();
        fill_rand(6);  send_line();
        frame_end();
        chk("A pure blue/red", (got_data.size() > 0) ? got_data[0] : -1, 32'hF0F);
        chk("A pure green", (got_data.size() > 1) ? got_data[1] : -1, 32'h0F0);
        chk("A frame_done", done_cnt, 1);
        chk("A overflow", overflow, 0);
        check_writes("frameA");

        // Frame B: full image of indexed pixels, then one extra line.
        done_cnt = 0;
        frame_start();
        for (int l = 0; l < H; l++) begin
            fill_k(W);
            send_line();
        end
        chk("B writes at full image", got_addr.size(), SIZE);
        chk("B overflow at full image", overflow, 0);
        fill_k(W);
        send_line();
        chk("B overflow after extra line", overflow, movf);
        chk("B overflow set", overflow, 1);
        frame_end();
        chk("B frame_done", done_cnt, 1);
        check_writes("frameB");
        chk("B overflow sticky before fs", overflow, 1);

        // Frame C: capture_en dropped mid-frame still completes the frame.
        done_cnt = 0;
        frame_start();
        chk("C overflow cleared at fs", overflow, 0);
        fill_rand(20); send_line();
        capture_en = 1'b0;
        fill_rand(20); send_line();
        frame_end();
        chk("C frame_done", done_cnt, 1);
        check_writes("frameC");

        // Frame D: FSM idle, frame ignored.
        model_on = 1'b0; done_cnt = 0;
        frame_start();
        fill_rand(20); send_line();
        frame_end();
        chk("D frame_done while idle", done_cnt, 0);
        check_writes("frameD");

        // Frame E: reset hits on a lo byte mid-line.
        capture_en = 1'b1; model_on = 1'b1; done_cnt = 0;
        frame_start();
        fill_rand(20); send_line();
        model_on = 1'b0;
        href = 1'b1; px_data = 8'hA5; tick(1);
        px_data = 8'h5A; rst = 1'b1;
        chk("E px_wr on rst cycle", px_wr, 0);
        tick(1);
        chk("E px_wr after rst", px_wr, 0);
        chk("E addr after rst", mem_px_addr, 0);
        chk("E data after rst", mem_px_data, 0);
        chk("E overflow after rst", overflow, 0);
        chk("E frame_done after rst", frame_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px_data = 8'($urandom); tick(1);
        end
        href = 1'b0; tick(2);
        frame_end();
        chk("E frame_done after rst", done_cnt, 0);
        check_writes("frameE");

        // Frame F: capture restarts from address 0.
        model_on = 1'b1; done_cnt = 0;
        frame_start();
        fill_rand(30); send_line();
        fill_rand(31); send_line();
        frame_end();
        chk("F frame_done", done_cnt, 1);
        check_writes("frameF");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Capture-side writer for the dual-port frame buffer: samples an OV7670-style camera byte stream (VSYNC, HREF, 8-bit data, RGB565, two bytes per pixel), packs each pixel to RGB444, and drives the buffer's write port (address, data, write strobe). It sits between the camera pads and the frame buffer. The VGA reader consumes the buffer through the other port. The block writes only addresses 0 to IMG_W*IMG_H-1, which leaves address IMG_W*IMG_H as the reader's black out-of-image pixel.

## Interface
Parameters:
- AW, 15: write-address width; must satisfy 2**AW > IMG_W*IMG_H
- DW, 12: pixel width, RGB444 packed {R[3:0],G[3:0],B[3:0]}
- IMG_W, 160: pixels per line
- IMG_H, 120: lines per frame

Ports:
- clk  in  1  camera pixel clock; the single clock of the block
- rst  in  1  synchronous, active-high reset
- capture_en  in  1  level; capture frames while high
- vsync  in  1  camera frame sync; high during vertical blanking
- href  in  1  camera line valid; high while bytes are valid
- px_data  in  8  camera byte
- mem_px_addr  out  AW  buffer write address
- mem_px_data  out  DW  buffer write data
- px_wr  out  1  buffer write strobe, one cycle per pixel
- frame_done  out  1  one-cycle pulse at end of each captured frame
- overflow  out  1  sticky flag: the frame delivered more than IMG_W*IMG_H pixels

## Operation
- Reset: state IDLE. mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0, byte phase=0, vsync_q=0.
- vsync is registered each cycle as vsync_q.
  - Frame start (fs) = vsync_q & ~vsync.
  - Frame end (fe) = ~vsync_q & vsync.
- FSM states:
  - IDLE: capture_en=1 → WAIT_FS.
  - WAIT_FS: fs → CAPTURE; address counter cleared to 0, overflow cleared, byte phase cleared. If capture_en drops here → IDLE.
  - CAPTURE: process bytes while href=1. On fe → FRAME_END.
  - FRAME_END: frame_done=1 for this single cycle. Then → WAIT_FS if capture_en=1, else IDLE.
- capture_en is sampled only in IDLE, WAIT_FS and FRAME_END. Deasserting it mid-frame finishes the current frame.
- Byte packing, in CAPTURE with href=1:
  - Phase 0: latch px_data as hi byte; phase toggles to 1.
  - Phase 1: px_data is the lo byte. Form R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1]. Phase toggles to 0.
- href=0 forces phase to 0. An odd trailing byte is discarded.
- Write rules:
  - On a phase-1 byte with pixel count < IMG_W*IMG_H: register addr=count and the packed data, set px_wr=1 for one cycle, increment count.
  - When count = IMG_W*IMG_H: no write, count holds, overflow=1 until the next fs.
- mem_px_addr and mem_px_data hold their last values when px_wr=0.
- A short frame (fewer pixels) is not an error. frame_done still pulses, and unwritten locations keep their old contents.
- fe arriving with href=1 (malformed stream): fe wins. Any pending hi byte is dropped.

## Timing
- All outputs are registered.
- Latency: lo byte sampled at edge n → px_wr, mem_px_addr, mem_px_data valid in cycle n+1.
- Back-to-back pixels: px_wr pulses at most every second cycle. With a continuous href, writes occur in every other cycle.
- frame_done asserts the cycle after the edge where fe is detected.
- A new fs is accepted no earlier than the cycle after frame_done.
- rst has priority over every event, including mid-line: px_wr=0 in the cycle after rst is sampled, and the partial pixel is lost.
- Address arithmetic: AW-bit unsigned. The counter never exceeds IMG_W*IMG_H, so there is no wrap.

## Structure
- Package cam_pkg holds:
  - IMG_W, IMG_H
  - IMG_SIZE = IMG_W*IMG_H
  - BLACK_ADDR = IMG_SIZE
  - the FSM state enum (IDLE, WAIT_FS, CAPTURE, FRAME_END)
  - function rgb565_to_rgb444(hi, lo)
- One sub-module, cam_byte_pack: byte-phase register plus hi-byte latch, producing pix_valid/pix_data. It is combinationally valid on the lo byte. The top level registers the outputs and owns the FSM and counter.

## Test plan
- Reset then capture_en=1. Frame of 120 lines × 320 bytes, pixel k = bytes {k[15:8],k[7:0]} → 19200 px_wr pulses, addresses 0 to 19199 in order, each data equals rgb565_to_rgb444, frame_done once, overflow=0.
- Single pixel hi=0xF8, lo=0x1F → mem_px_data=0xF0F. Pixel 0x07,0xE0 → 0x0F0.
- Line of 7 bytes (odd) → 3 writes, 7th byte dropped. The next line's first pixel packs correctly.
- Frame of 121 lines → 19200 writes, overflow=1 after the last write, no write at address 19200. overflow clears at the next fs.
- capture_en deasserted mid-frame → the frame completes with frame_done, then the FSM sits in IDLE and ignores the next fs.
- rst pulsed on a phase-1 byte mid-line → no px_wr that cycle or the next, all outputs 0, IDLE. Capture restarts from address 0 on the following fs.
